ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit and the initiating side of the instruction-memory interface. It holds the fetch PC and drives the word address to instruction memory. Each returned instruction word is captured, together with its PC, into a small in-order buffer. Decode drains the buffer through a valid/ready handshake, and a redirect from execute flushes the buffer and restarts fetch at a new target.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- DEPTH, 2, buffer entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_addr  out  32  byte address to instruction memory; combinational read, data returns the same cycle
- imem_data  in  32  instruction word at imem_addr
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  restart target
- out_valid  out  1  buffer head valid toward decode
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction word
- out_pc  out  32  head instruction address

## Operation
- State:
  - fetch_pc: 32 bits
  - buffer: DEPTH entries of {pc, instr}
  - rd_ptr, wr_ptr: log2(DEPTH) bits each, wrap modulo DEPTH
  - count: 0..DEPTH
- imem_addr = fetch_pc at all times, including during reset, when it equals RESET_PC.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop). A push writes {fetch_pc, imem_data} at wr_ptr and sets fetch_pc ← fetch_pc + 4. The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Full buffer:
  - If the same cycle also pops, the push proceeds (simultaneous push and pop).
  - If there is no pop, fetch_pc holds and imem_data is ignored.
- Redirect has priority over push and pop:
  - count, rd_ptr and wr_ptr are cleared.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}. Misaligned low bits are silently dropped.
  - out_valid is forced to 0 in the redirect cycle (combinational on redirect_valid), so no pop is ever counted that cycle.
- out_valid = (count != 0) & !redirect_valid.
- out_instr and out_pc present the head entry when out_valid = 1 and are driven to 0 when out_valid = 0.
- Order is strictly program order with no drops or duplicates. Every pushed entry is either popped exactly once or flushed by a redirect.
- Reset on any edge with rst_n = 0, including mid-stream:
  - fetch_pc ← RESET_PC and count, rd_ptr, wr_ptr ← 0.
  - Result: out_valid = 0, out_instr = 0, out_pc = 0.
  - Stored entries are discarded and no push occurs on that edge.

## Timing
- First instruction: on the first edge with rst_n = 1, mem[RESET_PC] is pushed, and out_valid = 1 during the following cycle.
- Throughput: one instruction per cycle sustained while out_ready = 1.
- Redirect latency:
  - Redirect asserted in cycle N.
  - Cycle N+1: imem_addr = target.
  - Cycle N+2: out_valid = 1 with out_pc = target.
- Backpressure:
  - With out_ready = 0, the buffer fills after DEPTH cycles, after which fetch_pc stalls.
  - When out_ready rises, the pop and a refill push occur on the same edge, so there is no bubble.
- Registered outputs: out_instr, out_pc, and count-derived out_valid are sourced from flops.
- Combinational paths: only the redirect gating of out_valid and the out_ready → push path.

## Structure
- Shared types package:
  - Reuse u32_t.
  - Add fetch_entry_t: packed struct {u32_t pc; u32_t instr}.
  - Add INSTR_BYTES = 4.
- Sub-module fetch_buf: synchronous FIFO of fetch_entry_t, parameterised by DEPTH.
  - Ports: push, pop, flush, full, empty, head.
  - ifetch holds fetch_pc, the push/pop/redirect arbitration, and output gating.

## Test plan
- Reset and stream:
  - Stimulus: imem preloaded with word i = 32'h1000_0000 + i; RESET_PC = 0; out_ready = 1.
  - Response: after reset release, one beat per cycle with pc = 0, 4, 8, … and instr = 32'h1000_0000, 32'h1000_0001, …
- Backpressure:
  - Stimulus: hold out_ready = 0 for 6 cycles, then release.
  - Response:
    - imem_addr freezes at 8 once count = 2.
    - After release, beats continue at pc = 0, 4, 8, 12 with no gap or duplicate.
- Redirect mid-stream with full buffer:
  - Stimulus: redirect_pc = 32'h0000_0103 in cycle N.
  - Response:
    - out_valid = 0 in N and N+1.
    - Cycle N+2 shows pc = 32'h100, instr = mem[64].
    - Buffered entries never appear.
- Redirect coincident with out_ready = 1 on a valid head:
  - Response: the head is not consumed (out_valid = 0 that cycle), and the next beat is the redirect target.
- PC wrap:
  - Stimulus: redirect to 32'hFFFF_FFF8.
  - Response: beats at FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 for one edge with 2 entries buffered.
  - Response:
    - Next cycle: out_valid = 0, out_pc = 0, out_instr = 0, imem_addr = RESET_PC.
    - Streaming then restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch path: the word type, the
// {pc, instr} entry held in the fetch buffer, and the instruction size.
package ifetch_pkg;

  typedef logic [31:0] u32_t;

  typedef struct packed {
    u32_t pc;
    u32_t instr;
  } fetch_entry_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/ifetch_fetch_buf.sv
// In-order FIFO of fetched {pc, instr} entries. Flush clears occupancy and
// pointers; entry storage is left as is because the count gates it.
module fetch_buf
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[wr_ptr] <= data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the fetch PC, feeds imem, buffers returned words
// and hands them to decode in order; a redirect flushes and restarts fetch.
module ifetch
  import ifetch_pkg::*;
#(
  parameter u32_t RESET_PC = 32'h0000_0000,
  parameter int   DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  u32_t         fetch_pc;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t wr_entry;

  assign out_valid = !empty && !redirect_valid;
  assign pop       = out_valid && out_ready;
  // A pop frees a slot on the same edge, so a full buffer still refills.
  assign push      = !redirect_valid && (!full || pop);

  assign wr_entry  = '{pc: fetch_pc, instr: imem_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~u32_t'(INSTR_BYTES - 1);
    end else if (push) begin
      fetch_pc <= fetch_pc + u32_t'(INSTR_BYTES);
    end
  end

  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .data  (wr_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign imem_addr = fetch_pc;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios then random traffic,
// compared each cycle against a queue-based reference of the fetch stream.
module tb_ifetch;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int vectors = 0;
  int miscompares = 0;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          known = 1'b0;

  logic        s_valid;
  logic [31:0] s_pc, s_instr, s_addr;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_data = mem_word(imem_addr);

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs mid-cycle, check against the model, then let the
  // model take the same edge the DUT takes.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
    bit ev;
    @(negedge clk);
    rst_n = rst;
    redirect_valid = redir;
    redirect_pc = rpc;
    out_ready = rdy;
    #1;
    s_valid = out_valid;
    s_pc = out_pc;
    s_instr = out_instr;
    s_addr = imem_addr;
    ev = (q.size() != 0) && !redir;
    if (known) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      chk("out_pc", out_pc, ev ? q[0].pc : 32'h0);
      chk("out_instr", out_instr, ev ? q[0].instr : 32'h0);
      chk("imem_addr", imem_addr, m_pc);
    end
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_pc = 32'h0;
      known = 1'b1;
    end else if (redir) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (known) begin
      if (ev && rdy) void'(q.pop_front());
      if (q.size() < DEPTH) begin
        q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    // Reset and stream
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", {31'b0, s_valid}, 32'h0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("first_pc", s_pc, 32'h0);
    chk("first_instr", s_instr, 32'h1000_0000);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    chk("stream_pc", s_pc, 32'h18);

    // Backpressure from reset
    step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    chk("bp_addr_freeze", s_addr, 32'h8);
    step(1, 0, 0, 1);
    chk("bp_first_pc", s_pc, 32'h0);
    step(1, 0, 0, 1);
    chk("bp_second_pc", s_pc, 32'h4);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);

    // Redirect with full buffer, ready high on a valid head
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 32'h0000_0103, 1);
    chk("redir_n_valid", {31'b0, s_valid}, 32'h0);
    step(1, 0, 0, 1);
    chk("redir_n1_valid", {31'b0, s_valid}, 32'h0);
    chk("redir_n1_addr", s_addr, 32'h100);
    step(1, 0, 0, 1);
    chk("redir_n2_pc", s_pc, 32'h100);
    chk("redir_n2_instr", s_instr, 32'h1000_0040);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);

    // PC wrap
    step(1, 1, 32'hFFFF_FFF8, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    chk("wrap_last_pc", s_pc, 32'h0000_0004);

    // Reset mid-operation with two entries buffered
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("midrst_valid", {31'b0, s_valid}, 32'h0);
    chk("midrst_addr", s_addr, 32'h0);
    step(1, 0, 0, 1);
    chk("midrst_restart_pc", s_pc, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) != 0, ($urandom % 12) == 0, $urandom, ($urandom % 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
